// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage branch predictor: 2-bit counter encodings and reset value.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_STRONG_NT = 2'b00,
        BP_WEAK_NT   = 2'b01,
        BP_WEAK_T    = 2'b10,
        BP_STRONG_T  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e BP_CTR_RESET = BP_WEAK_NT;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function: taken moves toward STRONG_T, not-taken toward STRONG_NT.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       taken,
    output logic [1:0] ctr_out
);

    bp_ctr_e cur;
    bp_ctr_e nxt;

    assign cur = bp_ctr_e'(ctr_in);

    always_comb begin
        nxt = cur;
        case (cur)
            BP_STRONG_NT: nxt = taken ? BP_WEAK_NT  : BP_STRONG_NT;
            BP_WEAK_NT:   nxt = taken ? BP_WEAK_T   : BP_STRONG_NT;
            BP_WEAK_T:    nxt = taken ? BP_STRONG_T : BP_WEAK_NT;
            BP_STRONG_T:  nxt = taken ? BP_STRONG_T : BP_WEAK_T;
            default:      nxt = cur;
        endcase
    end

    assign ctr_out = nxt;

endmodule

// File: rtl/branch_predictor.sv
// IF-stage predictor: direct-mapped BTB + 2-bit counters, EX-side mispredict/redirect and training.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = XLEN - IDX_BITS - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_is_jalr,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    bp_ctr_e             ctr_q   [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic                if_hit;
    logic [IDX_BITS-1:0] res_idx;
    logic [TAG_BITS-1:0] res_tag;
    logic                res_hit;
    logic                train;
    logic [1:0]          ctr_next;

    assign if_idx  = pc_if[IDX_BITS+1:2];
    assign if_tag  = pc_if[XLEN-1:IDX_BITS+2];
    assign res_idx = res_pc[IDX_BITS+1:2];
    assign res_tag = res_pc[XLEN-1:IDX_BITS+2];

    // Lookup reads registered state, so a same-cycle update is seen one cycle later.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && (ctr_q[if_idx] inside {BP_WEAK_T, BP_STRONG_T});
    assign pred_target = pred_taken ? tgt_q[if_idx] : pc_if + XLEN'(4);

    assign mispredict  = res_valid &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_target)));
    assign redirect_pc = !mispredict ? '0 :
                         res_taken   ? res_target : res_pc + XLEN'(4);

    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    assign train   = res_valid && !res_is_jalr;

    bp_sat_counter u_sat_counter (
        .ctr_in  (ctr_q[res_idx]),
        .taken   (res_taken),
        .ctr_out (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_CTR_RESET;
            end
        end else if (train) begin
            if (res_hit) begin
                ctr_q[res_idx] <= bp_ctr_e'(ctr_next);
            end else if (res_taken) begin
                valid_q[res_idx] <= 1'b1;
                ctr_q[res_idx]   <= BP_WEAK_T;
            end
        end
    end

    // Tag/target payload needs no reset; it is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (!rst && train && res_taken) begin
            tag_q[res_idx] <= res_tag;
            tgt_q[res_idx] <= res_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res_valid && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_is_jalr;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .IDX_BITS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_if           (pc_if),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_is_jalr     (res_is_jalr),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one slot per index holding the full PC that owns it.
    bit          m_valid [64];
    logic [31:0] m_pc    [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    longint      m_br;
    longint      m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_pc[i] >> 8) == (pc >> 8));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic idle();
        res_valid       = 1'b0;
        res_pc          = '0;
        res_taken       = 1'b0;
        res_target      = '0;
        res_is_jalr     = 1'b0;
        res_pred_taken  = 1'b0;
        res_pred_target = '0;
    endtask

    // Presents a resolution whose piped prediction is what IF would have produced.
    task automatic resolve(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit jalr);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_taken       = taken;
        res_target      = tgt;
        res_is_jalr     = jalr;
        res_pred_taken  = m_pred_taken(pc);
        res_pred_target = m_pred_target(pc);
    endtask

    // Called just after a falling edge with inputs driven; checks, advances the model, then one clock.
    task automatic cycle();
        bit          exp_mp;
        logic [31:0] exp_rd;
        int          i;
        #1;
        if (!rst) begin
            check("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred_taken(pc_if)});
            check("pred_target", pred_target, m_pred_target(pc_if));
        end
        exp_mp = res_valid && ((res_taken != res_pred_taken) ||
                               (res_taken && (res_target != res_pred_target)));
        exp_rd = !exp_mp ? 32'd0 : (res_taken ? res_target : res_pc + 32'd4);
        check("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
        check("redirect_pc", redirect_pc, exp_rd);
`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, 32'(m_br));
        check("stat_mispredicts", stat_mispredicts, 32'(m_mis));
`endif
        if (rst) begin
            m_reset();
        end else begin
            if (res_valid && m_br < 64'hFFFF_FFFF) m_br++;
            if (exp_mp && m_mis < 64'hFFFF_FFFF) m_mis++;
            if (res_valid && !res_is_jalr) begin
                i = idx_of(res_pc);
                if (m_hit(res_pc)) begin
                    m_ctr[i] = res_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                         : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (res_taken) m_tgt[i] = res_target;
                end else if (res_taken) begin
                    m_valid[i] = 1'b1;
                    m_pc[i]    = res_pc;
                    m_tgt[i]   = res_target;
                    m_ctr[i]   = 2;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'($urandom_range(0, 3)) * 32'd256 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    initial begin
        rst   = 1'b1;
        pc_if = 32'h100;
        idle();
        m_reset();
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Cold lookup, then first allocation and its prediction.
        cycle();
        resolve(32'h100, 1'b1, 32'h80, 1'b0);
        cycle();
        idle();
        cycle();

        // Not-taken streak into STRONG_NT, then taken back to predicting taken.
        for (int k = 0; k < 5; k++) begin
            resolve(32'h100, 1'b0, 32'h0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            resolve(32'h100, 1'b1, 32'h80, 1'b0);
            cycle();
        end
        idle();
        cycle();

        // Alias at the same index evicts 0x100.
        resolve(32'h200, 1'b1, 32'h300, 1'b0);
        cycle();
        idle();
        cycle();

        // Wrong-target hit retrains the target; JALR never writes.
        resolve(32'h100, 1'b1, 32'h80, 1'b0);
        cycle();
        resolve(32'h100, 1'b1, 32'h90, 1'b0);
        cycle();
        resolve(32'h100, 1'b1, 32'hA0, 1'b1);
        cycle();
        idle();
        cycle();

        // Same-index update and lookup, then wraparound of pc+4.
        pc_if = 32'h140;
        resolve(32'h140, 1'b1, 32'h40, 1'b0);
        cycle();
        idle();
        cycle();
        pc_if = 32'hFFFF_FFFC;
        cycle();

        // Update during reset is dropped.
        rst   = 1'b1;
        pc_if = 32'h180;
        resolve(32'h180, 1'b1, 32'h20, 1'b0);
        cycle();
        rst = 1'b0;
        idle();
        cycle();

        for (int k = 0; k < 800; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            pc_if = rand_pc();
            if ($urandom_range(0, 3) != 0) begin
                resolve(rand_pc(), 1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC,
                        $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    res_pred_taken  = 1'($urandom_range(0, 1));
                    res_pred_target = 32'($urandom) & 32'hFFFF_FFFC;
                end
            end else begin
                idle();
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
